rv32m_mul_sequencer: RTL

//  Issue/retire stage in front of the iterative 32x32 multiplier core (control path + datapath).
//  - Accepts RV32M MUL/MULH/MULHSU/MULHU requests over a valid/ready handshake.
//  - Converts signed operands to magnitudes, clears and runs the core, then captures its 64-bit unsigned product.
//  - Applies sign correction and high/low selection, and returns a tagged result over a valid/ready handshake.

---
 rtl/rv32m_mul_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rv32m_mul_sequencer.sv
// ---------------------------------------------------------------------------
// rv32m_mul_sequencer
// Issue/retire stage for an iterative 32x32 unsigned multiplier core.
// Accepts RV32M MUL/MULH/MULHSU/MULHU requests, feeds operand magnitudes to
// the core, waits for its product (bounded by a timeout), applies sign
// correction and high/low selection, and returns a tagged result.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i/_ready_o request handshake (ready only while idle)
//   req_funct3_i        000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx unsupported
//   req_rs1_i/_rs2_i    operands
//   req_tag_i           request tag, echoed on the response
//   mult_clr_o          one-cycle clear pulse to the core
//   mult_en_o           core run enable
//   mult_a_o/_b_o       unsigned operand magnitudes to the core
//   mult_done_i         core done flag
//   mult_product_i      core 64-bit unsigned product
//   resp_valid_o/_ready_i response handshake
//   resp_data_o         32-bit result (0 on error)
//   resp_tag_o          echoed tag
//   resp_err_o          unsupported funct3 or core timeout
// ---------------------------------------------------------------------------
module rv32m_mul_sequencer #(
   parameter int MIN_LATENCY = 7,
   parameter int TIMEOUT     = 31,
   parameter int TAG_W       = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [2:0]       req_funct3_i,
   input  logic [31:0]      req_rs1_i,
   input  logic [31:0]      req_rs2_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             mult_clr_o,
   output logic             mult_en_o,
   output logic [31:0]      mult_a_o,
   output logic [31:0]      mult_b_o,
   input  logic             mult_done_i,
   input  logic [63:0]      mult_product_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [31:0]      resp_data_o,
   output logic [TAG_W-1:0] resp_tag_o,
   output logic             resp_err_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_LATENCY);
   localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_FIX   = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [63:0]      r_prod;
   logic             r_neg;
   logic             r_sel_hi;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic [31:0]      r_data;
   logic [TAG_W-1:0] r_tag;
   logic             r_err;
   logic             w_done_ok;
   logic             w_timeout;
   logic [63:0]      w_res64;

   // Magnitude of a signed 32-bit value; 0x80000000 maps to itself as unsigned.
   function automatic logic [31:0] f_mag(input logic [31:0] x);
      f_mag = x[31] ? (~x + 32'd1) : x;
   endfunction

   assign w_done_ok = mult_done_i && (r_cnt >= CNT_MIN);
   assign w_timeout = (r_cnt == CNT_TO);

   // Sign correction of the captured unsigned product.
   always_comb begin
      w_res64 = r_prod;
      if (r_neg) begin
         w_res64 = ~r_prod + 64'd1;
      end else begin
         w_res64 = r_prod;
      end
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; done outranks timeout when both hit in one RUN cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid_i) begin
               w_next = req_funct3_i[2] ? S_RESP : S_CLEAR;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_CLEAR: w_next = S_RUN;
         S_RUN: begin
            if (w_done_ok) begin
               w_next = S_FIX;
            end else if (w_timeout) begin
               w_next = S_RESP;
            end else begin
               w_next = S_RUN;
            end
         end
         S_FIX: w_next = S_RESP;
         S_RESP: begin
            if (resp_ready_i) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_RESP;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: operand capture, cycle counter, product capture, result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt    <= {CNT_W{1'b0}};
         r_prod   <= 64'd0;
         r_neg    <= 1'b0;
         r_sel_hi <= 1'b0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_data   <= 32'd0;
         r_tag    <= {TAG_W{1'b0}};
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_tag    <= req_tag_i;
                  r_sel_hi <= (req_funct3_i != 3'b000);
                  r_data   <= 32'd0;
                  r_err    <= req_funct3_i[2];
                  case (req_funct3_i[1:0])
                     2'b01: begin
                        r_a   <= f_mag(req_rs1_i);
                        r_b   <= f_mag(req_rs2_i);
                        r_neg <= req_rs1_i[31] ^ req_rs2_i[31];
                     end
                     2'b10: begin
                        r_a   <= f_mag(req_rs1_i);
                        r_b   <= req_rs2_i;
                        r_neg <= req_rs1_i[31];
                     end
                     default: begin
                        r_a   <= req_rs1_i;
                        r_b   <= req_rs2_i;
                        r_neg <= 1'b0;
                     end
                  endcase
               end
            end
            S_CLEAR: r_cnt <= {CNT_W{1'b0}};
            S_RUN: begin
               if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               end
               if (w_done_ok) begin
                  r_prod <= mult_product_i;
               end else if (w_timeout) begin
                  r_err  <= 1'b1;
                  r_data <= 32'd0;
               end
            end
            S_FIX: r_data <= r_sel_hi ? w_res64[63:32] : w_res64[31:0];
            S_RESP: r_data <= r_data;
            default: r_data <= r_data;
         endcase
      end
   end

   // Outputs are decoded directly from registered state/data.
   assign req_ready_o  = (r_state == S_IDLE);
   assign mult_clr_o   = (r_state == S_CLEAR);
   assign mult_en_o    = (r_state == S_RUN);
   assign resp_valid_o = (r_state == S_RESP);
   assign mult_a_o     = r_a;
   assign mult_b_o     = r_b;
   assign resp_data_o  = r_data;
   assign resp_tag_o   = r_tag;
   assign resp_err_o   = r_err;

endmodule
